// File: rtl/cnn_pkg.sv
// Shared definitions for the 5x5 convolution front end: loader FSM states
// and layer geometry limits, used by both the write loader and the read-address generator.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_I,
    FLUSH,
    CONV,
    DONE
  } loader_state_t;

  localparam int WGT_DEPTH = 25;
  localparam int DIM_MIN   = 5;
  localparam int DIM_MAX   = 32;

  function automatic logic dimLegal(input logic [5:0] d);
    return (d >= 6'(DIM_MIN)) && (d <= 6'(DIM_MAX));
  endfunction

endpackage

// File: rtl/conv_layer_loader_ram_write_port.sv
// Registered RAM write driver: one write per accepted word, address taken
// from a local counter that the owner clears at the start of each layer.
module ram_write_port #(
  parameter int AW = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr,
  input  logic          hold,
  input  logic [DW-1:0] data,
  output logic [AW-1:0] cnt,
  output logic          en,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] din
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      we   <= 1'b0;
      addr <= '0;
      din  <= '0;
    end else begin
      we <= wr;
      if (clear) begin
        cnt <= '0;
      end else if (wr) begin
        cnt  <= cnt + 1'b1;
        addr <= cnt;
        din  <= data;
      end
    end
  end

  // hold keeps the port enabled for the read side while the engine runs
  assign en = we | hold;

endmodule

// File: rtl/conv_layer_loader.sv
// Layer loader: streams 25 weight words then W*H image words into the RAMs,
// then holds convStart until the engine reports a fresh convFinish.
module conv_layer_loader #(
  parameter int DW        = 128,
  parameter int IMG_AW    = 10,
  parameter int WGT_AW    = 5,
  parameter int WGT_DEPTH = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        W,
  input  logic [5:0]        H,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  output logic              ramWeight_en,
  output logic              ramWeight_we,
  output logic [WGT_AW-1:0] ramWeight_addrW,
  output logic [DW-1:0]     ramWeight_din,
  output logic              ramImage_en,
  output logic              ramImage_we,
  output logic [IMG_AW-1:0] ramImage_addrW,
  output logic [DW-1:0]     ramImage_din,
  output logic              convStart,
  input  logic              convFinish,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import cnn_pkg::*;

  loader_state_t state, stateNxt;
  logic [10:0]       npix;
  logic              armed, errR;
  logic              legal, accept, hs, wgtWr, imgWr;
  logic [WGT_AW-1:0] wcnt;
  logic [IMG_AW-1:0] icnt;

  assign legal   = dimLegal(W) && dimLegal(H);
  assign accept  = (state == IDLE) && start && legal;
  assign s_ready = (state == LOAD_W) || (state == LOAD_I);
  assign hs      = s_valid && s_ready;
  assign wgtWr   = hs && (state == LOAD_W);
  assign imgWr   = hs && (state == LOAD_I);

  assign convStart = (state == CONV);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = errR;

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (accept) stateNxt = LOAD_W;
      LOAD_W:  if (wgtWr && wcnt == WGT_AW'(WGT_DEPTH - 1)) stateNxt = LOAD_I;
      LOAD_I:  if (imgWr && 11'(icnt) == npix - 11'd1) stateNxt = FLUSH;
      FLUSH:   stateNxt = CONV;
      CONV:    if (convFinish && armed) stateNxt = DONE;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      npix  <= '0;
      armed <= 1'b0;
      errR  <= 1'b0;
    end else begin
      state <= stateNxt;
      errR  <= (state == IDLE) && start && !legal;
      if (accept) npix <= 11'(W) * 11'(H);
      // a finish level left over from the previous layer must go low before it counts
      if (state != CONV)    armed <= 1'b0;
      else if (!convFinish) armed <= 1'b1;
    end
  end

  ram_write_port #(.AW(WGT_AW), .DW(DW)) uWgt (
    .clk(clk), .rst(rst), .clear(accept), .wr(wgtWr), .hold(convStart),
    .data(s_data), .cnt(wcnt), .en(ramWeight_en), .we(ramWeight_we),
    .addr(ramWeight_addrW), .din(ramWeight_din)
  );

  ram_write_port #(.AW(IMG_AW), .DW(DW)) uImg (
    .clk(clk), .rst(rst), .clear(accept), .wr(imgWr), .hold(convStart),
    .data(s_data), .cnt(icnt), .en(ramImage_en), .we(ramImage_we),
    .addr(ramImage_addrW), .din(ramImage_din)
  );

endmodule

// File: tb/tb_conv_layer_loader.sv
// Bench for conv_layer_loader: word-count reference model plus per-cycle
// output comparison and literal per-layer totals.
module tb_conv_layer_loader;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, s_valid = 1'b0, convFinish = 1'b0;
  logic [5:0]   W = '0, H = '0;
  logic [127:0] s_data = '0;
  logic         s_ready, ramWeight_en, ramWeight_we, ramImage_en, ramImage_we;
  logic         convStart, busy, done, err;
  logic [4:0]   ramWeight_addrW;
  logic [9:0]   ramImage_addrW;
  logic [127:0] ramWeight_din, ramImage_din;

  always #5 clk = ~clk;

  conv_layer_loader dut (
    .clk(clk), .rst(rst), .start(start), .W(W), .H(H),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ramWeight_en(ramWeight_en), .ramWeight_we(ramWeight_we),
    .ramWeight_addrW(ramWeight_addrW), .ramWeight_din(ramWeight_din),
    .ramImage_en(ramImage_en), .ramImage_we(ramImage_we),
    .ramImage_addrW(ramImage_addrW), .ramImage_din(ramImage_din),
    .convStart(convStart), .convFinish(convFinish),
    .busy(busy), .done(done), .err(err)
  );

  // Reference: a layer is a count of words; the first 25 go to weights, the rest to image
  localparam int M_IDLE = 0, M_LOAD = 1, M_FLUSH = 2, M_CONV = 3, M_DONE = 4;
  int           mph = M_IDLE, nWords = 0, total = 0;
  bit           seenLow = 1'b0;
  logic         expWeW = 1'b0, expWeI = 1'b0, expErr = 1'b0;
  logic [4:0]   expAW = '0;
  logic [9:0]   expAI = '0;
  logic [127:0] expD = '0;

  always @(posedge clk) begin
    expWeW = 1'b0;
    expWeI = 1'b0;
    expErr = 1'b0;
    if (rst) mph = M_IDLE;
    else case (mph)
      M_IDLE: if (start) begin
        if (W >= 5 && W <= 32 && H >= 5 && H <= 32) begin
          total = 25 + int'(W) * int'(H);
          nWords = 0;
          mph = M_LOAD;
        end else expErr = 1'b1;
      end
      M_LOAD: if (s_valid) begin
        expD = s_data;
        if (nWords < 25) begin expWeW = 1'b1; expAW = 5'(nWords); end
        else begin expWeI = 1'b1; expAI = 10'(nWords - 25); end
        nWords++;
        if (nWords == total) mph = M_FLUSH;
      end
      M_FLUSH: begin mph = M_CONV; seenLow = 1'b0; end
      M_CONV: if (convFinish && seenLow) mph = M_DONE; else if (!convFinish) seenLow = 1'b1;
      M_DONE: mph = M_IDLE;
      default: mph = M_IDLE;
    endcase
  end

  int nChk = 0, nPass = 0, cyc = 0;
  int wgtWrites = 0, imgWrites = 0, doneCount = 0, errCount = 0, overlap = 0, weConv = 0;
  int lastImgAddr = -1, convRise = 0, lastHs = 0;
  bit prevConv = 1'b0;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    nChk++;
    if (a === e) nPass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic compareCycle();
    bit inConv;
    cyc++;
    inConv = (mph == M_CONV);
    chk("s_ready", s_ready, mph == M_LOAD);
    chk("busy", busy, mph != M_IDLE);
    chk("convStart", convStart, inConv);
    chk("done", done, mph == M_DONE);
    chk("err", err, expErr);
    chk("wgt_we", ramWeight_we, expWeW);
    chk("img_we", ramImage_we, expWeI);
    chk("wgt_en", ramWeight_en, expWeW || inConv);
    chk("img_en", ramImage_en, expWeI || inConv);
    if (expWeW) begin
      chk("wgt_addr", ramWeight_addrW, expAW);
      chk("wgt_din", ramWeight_din, expD);
    end
    if (expWeI) begin
      chk("img_addr", ramImage_addrW, expAI);
      chk("img_din", ramImage_din, expD);
    end
    if (ramWeight_we && ramImage_we) overlap++;
    if (convStart && (ramWeight_we || ramImage_we)) weConv++;
    if (ramWeight_we) wgtWrites++;
    if (ramImage_we) begin imgWrites++; lastImgAddr = int'(ramImage_addrW); end
    if (done) doneCount++;
    if (err) errCount++;
    if (convStart && !prevConv) convRise = cyc;
    prevConv = convStart;
  endtask

  task automatic cycle();
    @(negedge clk);
    compareCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic startLayer(input int w, input int h);
    W = 6'(w); H = 6'(h); start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // mode 0: continuous, 1: every other cycle, 2: random gaps; ignAt pulses start mid-load
  task automatic stream(input int n, input int mode, input int ignAt);
    int sent = 0, i = 0;
    while (sent < n && i < n * 8) begin
      s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((i % 2) == 0) : ($urandom_range(0, 2) != 0);
      if (s_valid) begin
        s_data = {$urandom, $urandom, $urandom, $urandom};
        if (sent == ignAt) begin start = 1'b1; W = 6'd10; H = 6'd10; end
        sent++;
        lastHs = cyc + 1;
      end
      i++;
      cycle();
      start = 1'b0;
    end
    s_valid = 1'b0;
    chk("stream_words", sent, n);
  endtask

  task automatic finishConv(input int lowCycles);
    convFinish = 1'b0;
    repeat (lowCycles) cycle();
    convFinish = 1'b1;
    cycle();
    convFinish = 1'b0;
    repeat (3) cycle();
  endtask

  int bw, bi, bd, be;

  initial begin
    cycle();
    cycle();
    chk("rst s_ready", s_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst convStart", convStart, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst wgt_we", ramWeight_we, 0);
    chk("rst img_we", ramImage_we, 0);
    chk("rst wgt_en", ramWeight_en, 0);
    chk("rst img_en", ramImage_en, 0);
    chk("rst wgt_addr", ramWeight_addrW, 0);
    chk("rst img_addr", ramImage_addrW, 0);
    chk("rst img_din", ramImage_din, 0);
    rst = 1'b0;
    cycle();

    // 32x32, continuous stream
    bw = wgtWrites; bi = imgWrites; bd = doneCount;
    startLayer(32, 32);
    stream(25 + 1024, 0, -1);
    finishConv(3);
    chk("A wgt writes", wgtWrites - bw, 25);
    chk("A img writes", imgWrites - bi, 1024);
    chk("A last img addr", lastImgAddr, 1023);
    chk("A convStart delay", convRise - lastHs, 2);
    chk("A done count", doneCount - bd, 1);
    chk("A busy after", busy, 0);

    // 5x5, toggling valid, start during image load must be ignored
    bw = wgtWrites; bi = imgWrites; bd = doneCount;
    startLayer(5, 5);
    stream(50, 1, 30);
    finishConv(2);
    chk("B wgt writes", wgtWrites - bw, 25);
    chk("B img writes", imgWrites - bi, 25);
    chk("B last img addr", lastImgAddr, 24);
    chk("B done count", doneCount - bd, 1);

    // stale-high convFinish from the previous layer
    bd = doneCount;
    convFinish = 1'b1;
    startLayer(6, 5);
    stream(55, 2, -1);
    repeat (6) cycle();
    chk("C convStart held", convStart, 1);
    chk("C no done while stale", doneCount - bd, 0);
    convFinish = 1'b0;
    repeat (3) cycle();
    convFinish = 1'b1;
    repeat (4) cycle();
    convFinish = 1'b0;
    cycle();
    chk("C done once", doneCount - bd, 1);
    chk("C busy after", busy, 0);

    // illegal dimensions
    be = errCount;
    startLayer(4, 10); cycle();
    startLayer(33, 5); cycle();
    startLayer(12, 4); cycle();
    chk("err pulses", errCount - be, 3);
    chk("err busy", busy, 0);

    // reset during image load at icnt=100
    startLayer(32, 32);
    stream(125, 0, -1);
    rst = 1'b1;
    cycle();
    chk("midrst s_ready", s_ready, 0);
    chk("midrst wgt_we", ramWeight_we, 0);
    chk("midrst img_we", ramImage_we, 0);
    chk("midrst busy", busy, 0);
    rst = 1'b0;
    cycle();
    bw = wgtWrites; bi = imgWrites; bd = doneCount;
    startLayer(8, 8);
    stream(89, 2, -1);
    finishConv(3);
    chk("R wgt writes", wgtWrites - bw, 25);
    chk("R img writes", imgWrites - bi, 64);
    chk("R last img addr", lastImgAddr, 63);
    chk("R done count", doneCount - bd, 1);

    // 28x20, random gaps
    bi = imgWrites; bd = doneCount;
    startLayer(28, 20);
    stream(585, 2, -1);
    finishConv(4);
    chk("D img writes", imgWrites - bi, 560);
    chk("D last img addr", lastImgAddr, 559);
    chk("D done count", doneCount - bd, 1);
    chk("we overlap cycles", overlap, 0);
    chk("we during convStart", weConv, 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
